serial_tx_frame: RTL and testbench

- Transmitter side of a UART-style serial link. Built on the same clocked storage primitives as the flip-flop library.
- Accepts a parallel word through a valid/ready handshake.
- Shifts the word out on a single line, LSB first, framed by a start bit (0) and a stop bit (1). Each bit is held for a fixed number of clock cycles.
- Sits between a parallel producer and the serial line. The matching serial receiver is the other end.

---
 rtl/serial_tx_frame_if.sv | 12 +
 rtl/serial_tx_frame.sv | 156 +++++++++++++++
 tb/tb_serial_tx_frame.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/serial_tx_frame_if.sv
// Parallel word handshake between a producer and the serial transmitter.
// The producer drives data/valid, the transmitter answers with ready.
interface serial_tx_frame_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/serial_tx_frame.sv
// UART-style transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_tx_frame #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    serial_tx_frame_if.slave bus,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CycLast = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BitLast = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef SERIAL_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign bit_end = (cyc_q == CycLast);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.valid && ready_q) begin
                    state_d = StStart;
                    shift_d = bus.data;
                    cyc_d   = '0;
                    bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^bus.data;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = StData;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BitLast) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = StStop;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so derive them from the state being entered.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        ready_d = (state_d == StIdle);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.ready = ready_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_serial_tx_frame.sv
// Bench for serial_tx_frame: directed scenarios plus random traffic against a
// frame-level model that predicts the tx waveform as a queue of bit periods.
module tb_serial_tx_frame;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CPB   = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int unsigned PBITS = 1;
`else
    localparam int unsigned PBITS = 0;
`endif
    localparam int unsigned FRAME = (WIDTH + 2 + PBITS) * CPB;

    logic clock = 1'b0;
    logic reset;
    logic tx, busy, done;

    serial_tx_frame_if #(.WIDTH(WIDTH)) bus ();

    serial_tx_frame #(
        .WIDTH       (WIDTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    bit   exp_q[$];
    logic exp_tx    = 1'b1;
    logic exp_ready = 1'b1;
    logic exp_busy  = 1'b0;
    logic exp_done  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd();
        return WIDTH'($urandom);
    endfunction

    // Predict outputs for the cycle following an edge with the given inputs.
    task automatic model_edge(input logic r, input logic v, input logic [WIDTH-1:0] d);
        logic was_busy;
        was_busy = exp_busy;
        if (!r) begin
            exp_q.delete();
            exp_tx    = 1'b1;
            exp_ready = 1'b1;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
            return;
        end
        if (exp_ready && v) begin
            for (int k = 0; k < int'(CPB); k++) exp_q.push_back(1'b0);
            for (int i = 0; i < int'(WIDTH); i++)
                for (int k = 0; k < int'(CPB); k++) exp_q.push_back(d[i]);
            for (int k = 0; k < int'(CPB * PBITS); k++) exp_q.push_back(^d);
            for (int k = 0; k < int'(CPB); k++) exp_q.push_back(1'b1);
        end
        if (exp_q.size() > 0) begin
            exp_tx    = exp_q.pop_front();
            exp_ready = 1'b0;
            exp_busy  = 1'b1;
            exp_done  = 1'b0;
        end else begin
            exp_tx    = 1'b1;
            exp_ready = 1'b1;
            exp_busy  = 1'b0;
            exp_done  = was_busy;
        end
    endtask

    task automatic tick(input logic r, input logic v, input logic [WIDTH-1:0] d,
                        input string tag);
        reset     = r;
        bus.valid = v;
        bus.data  = d;
        model_edge(r, v, d);
        @(posedge clock);
        @(negedge clock);
        cycle++;
        check($sformatf("%s.tx@%0d", tag, cycle), 32'(tx), 32'(exp_tx));
        check($sformatf("%s.ready@%0d", tag, cycle), 32'(bus.ready), 32'(exp_ready));
        check($sformatf("%s.busy@%0d", tag, cycle), 32'(busy), 32'(exp_busy));
        check($sformatf("%s.done@%0d", tag, cycle), 32'(done), 32'(exp_done));
    endtask

    initial begin
        int ready_low;
        int done_at;
        reset     = 1'b0;
        bus.valid = 1'b0;
        bus.data  = '0;
        @(negedge clock);

        // Reset held with a pending request: nothing may start.
        repeat (3) tick(1'b0, 1'b1, 8'hFF, "rst");

        // 0xA5 frame, a stray request at cycle 10 and churning data throughout.
        tick(1'b1, 1'b1, 8'hA5, "a5");
        ready_low = 0;
        done_at   = 0;
        for (int c = 1; c <= int'(FRAME) + 2; c++) begin
            if (!bus.ready) ready_low++;
            if (done && done_at == 0) done_at = c;
            if (c == 10) tick(1'b1, 1'b1, 8'h3C, "a5");
            else         tick(1'b1, 1'b0, rnd(), "a5");
        end
        check("a5_frame_len", 32'(ready_low), 32'(FRAME));
        check("a5_done_cycle", 32'(done_at), 32'(FRAME + 1));

        // Back-to-back: valid held high, second word accepted in the done cycle.
        tick(1'b1, 1'b1, 8'h01, "b2b");
        repeat (FRAME) tick(1'b1, 1'b1, 8'h01, "b2b");
        check("b2b_done", 32'(done), 32'd1);
        tick(1'b1, 1'b1, 8'h80, "b2b");
        check("b2b_start", 32'(tx), 32'd0);
        repeat (FRAME + 1) tick(1'b1, 1'b0, rnd(), "b2b");

        // Reset at cycle 15 aborts the frame; a following frame is clean.
        tick(1'b1, 1'b1, 8'hA5, "mrst");
        repeat (14) tick(1'b1, 1'b0, rnd(), "mrst");
        tick(1'b0, 1'b0, rnd(), "mrst");
        check("mrst_tx", 32'(tx), 32'd1);
        check("mrst_ready", 32'(bus.ready), 32'd1);
        tick(1'b1, 1'b1, 8'h5A, "5a");
        repeat (FRAME + 1) tick(1'b1, 1'b0, rnd(), "5a");

`ifdef SERIAL_TX_PARITY_EN
        tick(1'b1, 1'b1, 8'hA5, "par");
        repeat ((WIDTH + 1) * CPB) tick(1'b1, 1'b0, rnd(), "par");
        check("par_a5", 32'(tx), 32'd0);
        repeat (FRAME - (WIDTH + 1) * CPB) tick(1'b1, 1'b0, rnd(), "par");
        check("par_a5_done", 32'(done), 32'd1);
        tick(1'b1, 1'b1, 8'h07, "par");
        repeat ((WIDTH + 1) * CPB) tick(1'b1, 1'b0, rnd(), "par");
        check("par_07", 32'(tx), 32'd1);
        repeat (FRAME - (WIDTH + 1) * CPB) tick(1'b1, 1'b0, rnd(), "par");
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 1200; i++) begin
            tick(($urandom_range(0, 79) != 0), ($urandom_range(0, 3) == 0), rnd(), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
